cacheline_adapter: RTL
======================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, burst beat width; BURST = LINE_W/BEAT_W = 4.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dfp_addr  input  32  line address from cache.
REQ-006 SHALL have port dfp_read  input  1  line fill request, held until dfp_resp.
REQ-007 SHALL have port dfp_write  input  1  line writeback request, held until dfp_resp.
REQ-008 SHALL have port dfp_rdata  output  256  assembled fill line.
REQ-009 SHALL have port dfp_wdata  input  256  writeback line.
REQ-010 SHALL have port dfp_resp  output  1  one-cycle completion pulse.
REQ-011 SHALL have port bmem_addr  output  32  burst base address, bits [4:0] zero.
REQ-012 SHALL have port bmem_read  output  1  one-cycle read burst request.
REQ-013 SHALL have port bmem_write  output  1  write beat valid.
REQ-014 SHALL have port bmem_wdata  output  64  write beat data.
REQ-015 SHALL have port bmem_ready  input  1  memory can accept a new burst.
REQ-016 SHALL have port bmem_raddr  input  32  base address of returning beat.
REQ-017 SHALL have port bmem_rdata  input  64  read beat data.
REQ-018 SHALL have port bmem_rvalid  input  1  read beat valid.

Function
REQ-019 SHALL implement FSM states IDLE, RD_ISSUE, RD_COLLECT, WR_BURST, RESP.
REQ-020 SHALL, in IDLE with bmem_ready=1, latch {dfp_addr[31:5],5'b0} and dfp_wdata; dfp_write -> WR_BURST, else dfp_read -> RD_ISSUE.
REQ-021 SHALL give dfp_write priority when dfp_read and dfp_write are both high in IDLE.
REQ-022 SHALL stay in IDLE, driving no bmem request, while bmem_ready=0.
REQ-023 SHALL, in RD_ISSUE, assert bmem_read=1 for exactly one cycle with bmem_addr = latched address, then enter RD_COLLECT.
REQ-024 SHALL, in RD_COLLECT, store bmem_rdata into line slice [64*k +: 64] on each bmem_rvalid, k = 2-bit beat counter starting at 0; non-valid cycles leave buffer and counter unchanged.
REQ-025 SHALL enter RESP on the cycle after the beat with k=3 is captured.
REQ-026 SHALL, in WR_BURST, assert bmem_write=1 for exactly 4 consecutive cycles, bmem_addr = latched address, bmem_wdata = latched line slice k (k=0..3), then enter RESP.
REQ-027 SHALL, in RESP, assert dfp_resp=1 for exactly one cycle, drive dfp_rdata = assembled line (read) and return to IDLE; no request is accepted during RESP.
REQ-028 SHALL hold dfp_rdata stable from RESP until the next read's first beat is captured.
REQ-029 SHALL ignore bmem_rvalid outside RD_COLLECT.
REQ-030 SHALL drive bmem_read, bmem_write, dfp_resp to 0 in every state not listed as asserting them.
REQ-031 SHALL give read latency = 1 (IDLE) + 1 (RD_ISSUE) + beat arrival + 1 (RESP) cycles; write latency = 1 + 4 + 1 = 6 cycles from request to dfp_resp.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, enter IDLE, clear beat counter, clear line buffer and latched address to 0, in any state including mid-burst.
REQ-033 SHALL drive all outputs 0 during and immediately after reset.

Configuration
REQ-034 SHALL, with CLINE_ADAPTER_RADDR_CHECK_EN defined, capture a beat only when bmem_rvalid=1 and bmem_raddr equals the latched address; mismatching beats are dropped, counter unchanged.
REQ-035 SHALL, without CLINE_ADAPTER_RADDR_CHECK_EN, ignore bmem_raddr entirely.

Verification
REQ-036 SHALL cover read: dfp_read, addr 0x0000_1234 -> bmem_read one cycle with bmem_addr 0x0000_1220; beats 0x11..,0x22..,0x33..,0x44.. -> dfp_rdata {0x44..,0x33..,0x22..,0x11..}, single dfp_resp pulse.
REQ-037 SHALL cover write: dfp_write, addr 0x8000_0040, wdata beats A,B,C,D -> bmem_write high 4 cycles carrying A,B,C,D, dfp_resp at cycle 6.
REQ-038 SHALL cover both dfp_read and dfp_write high -> write burst issued first, no bmem_read.
REQ-039 SHALL cover bmem_ready=0 for 5 cycles then 1 -> no bmem request until ready, then normal read.
REQ-040 SHALL cover rst after beat 2 of a read -> IDLE, outputs 0, next read assembles all 4 new beats correctly.
REQ-041 SHALL cover, with CLINE_ADAPTER_RADDR_CHECK_EN, a beat with bmem_raddr 0xDEAD_0000 interleaved -> dropped, line unaffected.

Source files
------------

// File: rtl/cacheline_adapter.sv
// Adapts a cache line fill/writeback port onto a fixed-length beat burst memory.
// Optional `define CLINE_ADAPTER_RADDR_CHECK_EN: only accept read beats whose bmem_raddr matches the line address.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  output logic [LINE_W-1:0] dfp_rdata,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);
  // Handshake: dfp_read/dfp_write are held by the cache until the single-cycle
  // dfp_resp; bmem_read is a one-cycle burst request issued only after bmem_ready
  // was seen in IDLE; bmem_write marks each of the BURST write beats as valid;
  // bmem_rvalid qualifies one returning beat per cycle and has no backpressure.

  localparam int BURST = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BURST);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_COLLECT = 3'd2,
    WR_BURST   = 3'd3,
    RESP       = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic              bmem_read_q, bmem_read_d;
  logic              bmem_write_q, bmem_write_d;
  logic              dfp_resp_q, dfp_resp_d;
  logic              beat_ok;
  logic              unused_bits;

`ifdef CLINE_ADAPTER_RADDR_CHECK_EN
  assign beat_ok     = bmem_rvalid && (bmem_raddr == addr_q);
  assign unused_bits = ^dfp_addr[OFF_W-1:0];
`else
  assign beat_ok     = bmem_rvalid;
  assign unused_bits = ^{bmem_raddr, dfp_addr[OFF_W-1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rline_d = rline_q;
    wline_d = wline_q;
    case (state_q)
      IDLE: begin
        if (bmem_ready && (dfp_read || dfp_write)) begin
          addr_d  = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          wline_d = dfp_wdata;
          cnt_d   = '0;
          state_d = dfp_write ? WR_BURST : RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_COLLECT;
      RD_COLLECT: begin
        if (beat_ok) begin
          rline_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = RESP;
        end
      end
      WR_BURST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered: decode them from the state being entered.
    bmem_read_d  = (state_d == RD_ISSUE);
    bmem_write_d = (state_d == WR_BURST);
    dfp_resp_d   = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      rline_q      <= '0;
      wline_q      <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      dfp_resp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rline_q      <= rline_d;
      wline_q      <= wline_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      dfp_resp_q   <= dfp_resp_d;
    end
  end

  assign dfp_rdata  = rline_q;
  assign dfp_resp   = dfp_resp_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  // During WR_BURST the beat counter indexes the slice being sent.
  assign bmem_wdata = bmem_write_q ? wline_q[int'(cnt_q)*BEAT_W +: BEAT_W] : '0;

endmodule
